// File: rtl/register_file_param.sv
// Parametrised general-purpose register bank: two prioritised write ports, two
// combinational read ports with optional forwarding, and a one-register-per-cycle clear sweep.
module register_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en2,
  input  logic [ADDR_W-1:0] write_addr2,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_port1,
  output logic [DATA_W-1:0] read_port2,
  input  logic              clear_req,
  output logic              busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] cnt_r, cnt_next_s;
  logic              busy_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              accept1_s, accept2_s;
  logic [DATA_W-1:0] read1_s, read2_s;

  // True when an address is the hardwired-zero register in this configuration.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == ZERO_ADDR);
  endfunction

  // Write acceptance: enabled, not sweeping, not in reset, not aimed at the zero register.
  always_comb begin
    accept1_s = 1'b0;
    accept2_s = 1'b0;
    if (!rst && !busy_r) begin
      accept1_s = write_en  && !is_zero_reg(write_addr);
      accept2_s = write_en2 && !is_zero_reg(write_addr2);
    end else begin
      accept1_s = 1'b0;
      accept2_s = 1'b0;
    end
  end

  // Clear-sweep next-state logic; the counter wraps to 0 as the sweep ends.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clear_req) begin
          state_next_s = SWEEP;
          cnt_next_s   = ZERO_ADDR;
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = cnt_r;
        end
      end
      SWEEP: begin
        cnt_next_s = cnt_r + ONE_ADDR;
        if (cnt_r == LAST_ADDR) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SWEEP;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = ZERO_ADDR;
      end
    endcase
  end

  // Sweep state, counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= ZERO_ADDR;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      busy_r  <= (state_next_s == SWEEP);
    end
  end

  // Storage array: reset, sweep clearing, or writes with port 1 overriding port 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ZERO_DATA;
      end
    end else if (state_r == SWEEP) begin
      mem_r[cnt_r] <= ZERO_DATA;
    end else begin
      if (accept2_s) begin
        mem_r[write_addr2] <= data_in2;
      end
      if (accept1_s) begin
        mem_r[write_addr] <= data_in;
      end
    end
  end

  // Read port 1 with optional forwarding of same-cycle accepted writes.
  always_comb begin
    read1_s = mem_r[read_addr1];
    if (is_zero_reg(read_addr1)) begin
      read1_s = ZERO_DATA;
    end else if (BYPASS && accept1_s && (write_addr == read_addr1)) begin
      read1_s = data_in;
    end else if (BYPASS && accept2_s && (write_addr2 == read_addr1)) begin
      read1_s = data_in2;
    end else begin
      read1_s = mem_r[read_addr1];
    end
  end

  // Read port 2, same forwarding priority as port 1.
  always_comb begin
    read2_s = mem_r[read_addr2];
    if (is_zero_reg(read_addr2)) begin
      read2_s = ZERO_DATA;
    end else if (BYPASS && accept1_s && (write_addr == read_addr2)) begin
      read2_s = data_in;
    end else if (BYPASS && accept2_s && (write_addr2 == read_addr2)) begin
      read2_s = data_in2;
    end else begin
      read2_s = mem_r[read_addr2];
    end
  end

  assign read_port1 = read1_s;
  assign read_port2 = read2_s;
  assign busy       = busy_r;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench: three configurations share one stimulus (bypass, no bypass, zero register).
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en, write_en2, clear_req;
  logic [3:0]  write_addr, write_addr2, read_addr1, read_addr2;
  logic [15:0] data_in, data_in2;
  logic [15:0] rp1, rp2, nb_rp1, nb_rp2, zr_rp1, zr_rp2;
  logic        busy, nb_busy, zr_busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] model [16];

  always #5 clk = ~clk;

  register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .data_in(data_in),
    .write_en2(write_en2), .write_addr2(write_addr2), .data_in2(data_in2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_port1(rp1), .read_port2(rp2),
    .clear_req(clear_req), .busy(busy));

  register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .data_in(data_in),
    .write_en2(write_en2), .write_addr2(write_addr2), .data_in2(data_in2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_port1(nb_rp1), .read_port2(nb_rp2),
    .clear_req(clear_req), .busy(nb_busy));

  register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_zr (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .data_in(data_in),
    .write_en2(write_en2), .write_addr2(write_addr2), .data_in2(data_in2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_port1(zr_rp1), .read_port2(zr_rp2),
    .clear_req(clear_req), .busy(zr_busy));

  typedef struct {
    logic        we;  logic [3:0] wa;  logic [15:0] d;
    logic        we2; logic [3:0] wa2; logic [15:0] d2;
    logic [3:0]  ra1; logic [3:0] ra2;
    logic [15:0] exp1; logic [15:0] exp2;
    logic [15:0] nb1;  logic [15:0] zr1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en = 1'b0; write_addr = 4'd0; data_in = 16'h0000;
    write_en2 = 1'b0; write_addr2 = 4'd0; data_in2 = 16'h0000;
    clear_req = 1'b0;
  endtask

  initial begin
    int c;
    int busy_cycles;

    rst = 1'b1;
    idle_inputs();
    read_addr1 = 4'd0; read_addr2 = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state: every address reads zero, busy low.
    check("reset_busy", {15'd0, busy}, 16'h0000);
    for (int a = 0; a < 16; a++) begin
      read_addr1 = 4'(a); read_addr2 = 4'(15 - a);
      #1;
      check("reset_rp1", rp1, 16'h0000);
      check("reset_rp2", rp2, 16'h0000);
    end

    //           we   wa    d        we2  wa2   d2       ra1   ra2   exp1     exp2     nb1      zr1
    vecs[0] = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd4, 16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, 4'd5, 4'd5, 16'h1111, 16'h1111, 16'h0000, 16'h1111};
    vecs[3] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'h1111, 16'h1111, 16'h1111, 16'h1111};
    vecs[4] = '{1'b1, 4'd6, 16'h6666, 1'b1, 4'd7, 16'h7777, 4'd6, 4'd7, 16'h6666, 16'h7777, 16'h0000, 16'h6666};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd6, 4'd7, 16'h6666, 16'h7777, 16'h6666, 16'h6666};
    vecs[6] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hA5A5, 4'd0, 4'd0, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000};
    vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd3, 16'hA5A5, 16'hBEEF, 16'hA5A5, 16'h0000};
    vecs[8] = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 16'hA5A5, 16'h0000};
    vecs[9] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd5, 16'hFFFF, 16'h1111, 16'hFFFF, 16'h0000};

    for (int i = 0; i < 10; i++) begin
      write_en = vecs[i].we;   write_addr = vecs[i].wa;   data_in = vecs[i].d;
      write_en2 = vecs[i].we2; write_addr2 = vecs[i].wa2; data_in2 = vecs[i].d2;
      read_addr1 = vecs[i].ra1; read_addr2 = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rp1", i), rp1, vecs[i].exp1);
      check($sformatf("vec%0d_rp2", i), rp2, vecs[i].exp2);
      check($sformatf("vec%0d_nb_rp1", i), nb_rp1, vecs[i].nb1);
      check($sformatf("vec%0d_zr_rp1", i), zr_rp1, vecs[i].zr1);
      tick();
    end
    idle_inputs();

    // Fill every register with a non-zero pattern, two per cycle.
    for (int k = 0; k < 16; k += 2) begin
      write_en = 1'b1;  write_addr = 4'(k);      data_in = 16'h1000 | 16'(k);
      write_en2 = 1'b1; write_addr2 = 4'(k + 1); data_in2 = 16'h1000 | 16'(k + 1);
      model[k] = 16'h1000 | 16'(k);
      model[k + 1] = 16'h1000 | 16'(k + 1);
      tick();
    end

    // Clear request with a same-cycle write: the write commits, then gets swept.
    write_en = 1'b1; write_addr = 4'd9; data_in = 16'h9999;
    write_en2 = 1'b0;
    clear_req = 1'b1;
    read_addr1 = 4'd9;
    #1;
    check("clr_edge_bypass", rp1, 16'h9999);
    model[9] = 16'h9999;
    tick();
    idle_inputs();
    check("busy_rise", {15'd0, busy}, 16'h0001);

    c = 0;
    busy_cycles = 0;
    while (busy && c < 40) begin
      busy_cycles++;
      idle_inputs();
      read_addr1 = 4'(c == 0 ? 0 : c - 1);
      read_addr2 = 4'(c);
      if (c == 1) begin
        write_en = 1'b1; write_addr = 4'd2; data_in = 16'h2BAD;
        read_addr1 = 4'd2;
      end
      if (c == 5) clear_req = 1'b1;
      #1;
      check($sformatf("sweep%0d_rp1", c), rp1, (int'(read_addr1) < c) ? 16'h0000 : model[read_addr1]);
      check($sformatf("sweep%0d_rp2", c), rp2, model[read_addr2]);
      tick();
      c++;
    end
    idle_inputs();
    check("busy_cycles", 16'(busy_cycles), 16'd16);

    for (int a = 0; a < 16; a++) begin
      read_addr1 = 4'(a);
      #1;
      check($sformatf("after_sweep_%0d", a), rp1, 16'h0000);
      model[a] = 16'h0000;
    end

    // First write after busy falls is accepted on this edge.
    write_en = 1'b1; write_addr = 4'd4; data_in = 16'h4444;
    read_addr1 = 4'd4;
    #1;
    check("post_sweep_bypass", rp1, 16'h4444);
    tick();
    idle_inputs();
    read_addr2 = 4'd2;
    #1;
    check("post_sweep_stored", rp1, 16'h4444);
    check("dropped_write_addr2", rp2, 16'h0000);
    check("no_extra_sweep", {15'd0, busy}, 16'h0000);
    tick();
    check("no_extra_sweep2", {15'd0, busy}, 16'h0000);

    // Reset in the middle of a sweep.
    for (int k = 1; k < 4; k++) begin
      write_en = 1'b1; write_addr = 4'(k + 8); data_in = 16'h5500 | 16'(k);
      tick();
    end
    idle_inputs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    c = 0;
    while (c < 4 && c < 40) begin
      tick();
      c++;
    end
    check("busy_before_rst", {15'd0, busy}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {15'd0, busy}, 16'h0000);
    for (int a = 0; a < 16; a++) begin
      read_addr1 = 4'(a);
      #1;
      check($sformatf("rst_mid_%0d", a), rp1, 16'h0000);
    end
    tick();
    tick();
    check("sweep_not_resumed", {15'd0, busy}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
